// File: rtl/alu_mc.sv
// alu_mc: execute-stage ALU using MIPS funct codes.
// Single-cycle logic/add ops, plus a shift-add MULTU that takes WIDTH cycles.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b011001;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t state;

  logic is_add;
  logic is_sub;
  logic is_and;
  logic is_or;
  logic is_nor;
  logic is_slt;
  logic is_mul;

  assign is_add = (sel == F_ADD);
  assign is_sub = (sel == F_SUB);
  assign is_and = (sel == F_AND);
  assign is_or  = (sel == F_OR);
  assign is_nor = (sel == F_NOR);
  assign is_slt = (sel == F_SLT);
  assign is_mul = (sel == F_MUL);

  // Shared adder; split at the MSB to expose carry-in and carry-out.
  logic [WIDTH-1:0] bx;
  logic             cin;
  logic [WIDTH-1:0] lo;
  logic [1:0]       top;
  logic [WIDTH-1:0] sum;
  logic             c_msb;
  logic             c_out;
  logic             add_ovf;
  logic             slt;

  assign cin = sel[1];
  assign bx  = sel[1] ? ~b : b;
  assign lo  = {1'b0, a[WIDTH-2:0]}
             + {1'b0, bx[WIDTH-2:0]}
             + {{(WIDTH-1){1'b0}}, cin};
  assign c_msb = lo[WIDTH-1];
  assign top = {1'b0, a[WIDTH-1]}
             + {1'b0, bx[WIDTH-1]}
             + {1'b0, c_msb};
  assign sum     = {top[0], lo[WIDTH-2:0]};
  assign c_out   = top[1];
  assign add_ovf = c_msb ^ c_out;
  assign slt     = sum[WIDTH-1] ^ add_ovf;

  logic [WIDTH-1:0] res;
  logic             res_ovf;

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    unique case (1'b1)
      is_add,
      is_sub: begin
        res     = sum;
        res_ovf = add_ovf;
      end
      is_and: res = a & b;
      is_or:  res = a | b;
      is_nor: res = ~(a | b);
      is_slt: res = {{(WIDTH-1){1'b0}}, slt};
      default: ;
    endcase
  end

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-2:0] acc_lo;
  logic [WIDTH:0]   upper;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [CW-1:0]    cnt;

  // The bit shifted out of the low word is never needed again,
  // so only its upper WIDTH-1 bits are kept between iterations.
  assign part   = mplier[0] ? mcand : '0;
  assign upper  = {1'b0, acc_hi} + {1'b0, part};
  assign mul_hi = upper[WIDTH:1];
  assign mul_lo = {upper[0], acc_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      out    <= '0;
      hi     <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              mcand  <= a;
              mplier <= b;
              acc_hi <= '0;
              acc_lo <= '0;
              cnt    <= CW'(WIDTH - 1);
              busy   <= 1'b1;
              state  <= MUL;
            end else begin
              out  <= res;
              zero <= (res == '0);
              ovf  <= res_ovf;
              done <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_hi <= mul_hi;
          acc_lo <= mul_lo[WIDTH-1:1];
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            hi    <= mul_hi;
            out   <= mul_lo;
            zero  <= (mul_lo == '0);
            ovf   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
